// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the parity helper used by the receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

    // Expected parity bit for a word (zero-extended to 8 bits).
    // Even parity when odd_i = 0, odd parity when odd_i = 1.
    function automatic logic parity_expected(input logic [7:0] data_i,
                                             input logic       odd_i);
        return (^data_i) ^ odd_i;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit. The reset value is
// a parameter so idle-high lines (RX, CTS) come out of reset at their idle
// level and do not look like an edge.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    // Metastability-resolving flop pair.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN; the
// default build has no parity bit and o_parity_err is tied low.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_tick,
    input  logic            i_rx,
    input  logic            i_parity_odd,
    output logic [DBIT-1:0] o_data,
    output logic            o_valid,
    output logic            o_frame_err,
    output logic            o_parity_err,
    output logic            o_busy
);

    // Four bits cover one bit period; longer stop bits (1.5 / 2) need the
    // counter to reach SB_TICK-1, so it widens only when required.
    localparam int TCW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int BCW = $clog2(DBIT);

    localparam logic [TCW-1:0] TICK_MID  = TCW'(MID_TICK);
    localparam logic [TCW-1:0] TICK_LAST = TCW'(OVERSAMPLE - 1);
    localparam logic [TCW-1:0] TICK_STOP = TCW'(SB_TICK - 1);
    localparam logic [TCW-1:0] TICK_ONE  = TCW'(1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(DBIT - 1);
    localparam logic [BCW-1:0] BIT_ONE   = BCW'(1);

    logic rx_s;

    uart_rx_state_t  state_q,    state_d;
    logic [TCW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [BCW-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [DBIT-1:0] shreg_q,    shreg_d;
    logic [DBIT-1:0] data_q,     data_d;
    logic            valid_q,    valid_d;
    logic            ferr_q,     ferr_d;
    logic            perr_q,     perr_d;
    logic            busy_q;

`ifdef UART_RX_PARITY_EN
    logic            par_q,      par_d;
`else
    logic            parity_unused_s;
    assign parity_unused_s = i_parity_odd;
`endif

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx),
        .o_q   (rx_s)
    );

    // State, counters, shift register and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            busy_q     <= (state_d != IDLE);
`ifdef UART_RX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    // Next-state logic: start detection, mid-bit sampling and word delivery.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        perr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = par_q;
`endif

        case (state_q)
            IDLE: begin
                // Leaving IDLE does not wait for a tick.
                if (!rx_s) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end

            START: begin
                if (i_tick) begin
                    if (tick_cnt_q == TICK_MID) begin
                        if (!rx_s) begin
                            state_d    = DATA;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end else begin
                            // Line went back high: glitch, drop it silently.
                            state_d = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_ONE;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end

            DATA: begin
                if (i_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        shreg_d    = {rx_s, shreg_q[DBIT-1:1]};
                        tick_cnt_d = '0;
                        if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_ONE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_ONE;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (i_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        par_d      = rx_s;
                        tick_cnt_d = '0;
                        state_d    = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_ONE;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
`endif

            STOP: begin
                if (i_tick) begin
                    if (tick_cnt_q == TICK_STOP) begin
                        data_d     = shreg_q;
                        valid_d    = 1'b1;
                        ferr_d     = ~rx_s;
                        tick_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        perr_d = (par_q != parity_expected(8'(shreg_q), i_parity_odd));
`else
                        perr_d = 1'b0;
`endif
                        // A low stop bit may be a break; wait for the line
                        // to recover before hunting for the next start.
                        if (rx_s) begin
                            state_d = IDLE;
                        end else begin
                            state_d = WAIT_HIGH;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_ONE;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end

            WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_HIGH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_frame_err  = ferr_q;
    assign o_parity_err = perr_q;
    assign o_busy       = busy_q;

endmodule
